// File: rtl/keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : keypad_scanner                                               |
// | Description : 4x4 matrix keypad column scanner with scan-level debounce,   |
// |               single-key acceptance and registered key outputs.            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module keypad_scanner #(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int                  c_TICK_W    = $clog2(SCAN_TICKS);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(SCAN_TICKS - 1);
    localparam logic [3:0]          c_DEB_DONE  = 4'(DEBOUNCE_SCANS);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] c_ST_PRESSED  = 2'd2;
    localparam logic [1:0] c_ST_RELEASE  = 2'd3;

    logic [3:0]          r_sync1, r_sync2;
    logic [c_TICK_W-1:0] r_tick;
    logic [1:0]          r_col_idx;
    logic [3:0]          r_col;
    logic [1:0]          r_acc_hits;   // saturating: 0, 1, 2 = two or more
    logic [3:0]          r_acc_code;
    logic [1:0]          r_state;
    logic [3:0]          r_cnt, r_cand, r_key_code;
    logic                r_key_valid, r_key_held;

    logic       w_sample, w_scan_done;
    logic [3:0] w_row_act;
    logic [1:0] w_col_hits, w_col_row, w_scan_hits;
    logic [2:0] w_hit_sum;
    logic [3:0] w_scan_code;
    logic [1:0] w_state_nxt;
    logic [3:0] w_cnt_nxt, w_cand_nxt, w_code_nxt, w_cnt_inc;
    logic       w_valid_nxt;

    assign w_sample    = (r_tick == c_TICK_LAST);
    assign w_scan_done = w_sample && (r_col_idx == 2'd3);
    assign w_row_act   = ~r_sync2;

    always_comb begin
        w_col_hits = 2'd0;
        w_col_row  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_row_act[i]) begin
                w_col_row  = 2'(i);
                w_col_hits = (w_col_hits == 2'd0) ? 2'd1 : 2'd2;
            end
        end
    end

    assign w_hit_sum   = {1'b0, r_acc_hits} + {1'b0, w_col_hits};
    assign w_scan_hits = (w_hit_sum >= 3'd2) ? 2'd2 : w_hit_sum[1:0];
    assign w_scan_code = (r_acc_hits != 2'd0) ? r_acc_code : {w_col_row, r_col_idx};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 4'b1111;
            r_sync2    <= 4'b1111;
            r_tick     <= '0;
            r_col_idx  <= 2'd0;
            r_col      <= 4'b1110;
            r_acc_hits <= 2'd0;
            r_acc_code <= 4'd0;
        end else begin
            r_sync1 <= row;
            r_sync2 <= r_sync1;
            if (w_sample) begin
                r_tick    <= '0;
                r_col_idx <= r_col_idx + 2'd1;
                r_col     <= {r_col[2:0], r_col[3]};
                if (w_scan_done) begin
                    r_acc_hits <= 2'd0;
                    r_acc_code <= 4'd0;
                end else begin
                    r_acc_hits <= w_scan_hits;
                    r_acc_code <= w_scan_code;
                end
            end else begin
                r_tick <= r_tick + c_TICK_W'(1);
            end
        end
    end

    assign w_cnt_inc = r_cnt + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_code_nxt  = r_key_code;
        w_valid_nxt = 1'b0;
        if (w_scan_done) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_scan_hits == 2'd1) begin
                        w_state_nxt = c_ST_DEBOUNCE;
                        w_cand_nxt  = w_scan_code;
                        w_cnt_nxt   = 4'd1;
                    end
                end
                c_ST_DEBOUNCE: begin
                    if (w_scan_hits != 2'd1) begin
                        w_state_nxt = c_ST_IDLE;
                        w_cnt_nxt   = 4'd0;
                    end else if (w_scan_code != r_cand) begin
                        w_cand_nxt = w_scan_code;
                        w_cnt_nxt  = 4'd1;
                    end else if (w_cnt_inc == c_DEB_DONE) begin
                        w_state_nxt = c_ST_PRESSED;
                        w_cnt_nxt   = w_cnt_inc;
                        w_code_nxt  = r_cand;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                c_ST_PRESSED: begin
                    if (w_scan_hits == 2'd0) begin
                        w_state_nxt = c_ST_RELEASE;
                        w_cnt_nxt   = 4'd1;
                    end
                end
                default: begin
                    // Any key seen during release debounce reverts to held, silently
                    if (w_scan_hits != 2'd0) begin
                        w_state_nxt = c_ST_PRESSED;
                    end else if (w_cnt_inc == c_DEB_DONE) begin
                        w_state_nxt = c_ST_IDLE;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= 4'd0;
            r_cand      <= 4'd0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cand      <= w_cand_nxt;
            r_key_code  <= w_code_nxt;
            r_key_valid <= w_valid_nxt;
            r_key_held  <= (w_state_nxt == c_ST_PRESSED) || (w_state_nxt == c_ST_RELEASE);
        end
    end

    assign col       = r_col;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
`default_nettype wire
